pred_resolve: RTL and testbench
===============================

// Module: pred_resolve
// PURPOSE
//  Back end of the branch-prediction loop. Holds each fetched instruction's prediction in an in-order queue and compares it with the execute-stage result.
//  Drives the predictor update/redirect interface (branch_mistaken, wrong_pc, right_target, ins_type_w, update_orien_en, retire_pc, right_orien).
//  Sits between IF (push) and EX (resolve); its outputs feed pred and the front-end redirect mux.
// PARAMETERS
//  QDEPTH   8   prediction queue entries, power of 2, >= 4
//  QIDLEN   $clog2(QDEPTH)   pointer width (derived)
// PORTS
//  clk            in   1   clock
//  resetn         in   1   synchronous reset, active-low
//  push_valid_0   in   1   fetch slot 0 prediction valid
//  push_valid_1   in   1   fetch slot 1 valid; legal only with push_valid_0
//  push_pc_0/1    in   32  fetched instruction PC
//  push_taken_0/1 in   1   predicted taken
//  push_tgt_0/1   in   32  predicted next PC
//  push_ready     out  1   >= 2 free entries (comb from count)
//  res_valid      in   1   EX resolves the oldest instruction this cycle
//  res_pc         in   32  resolved PC
//  res_type       in   3   actual branch type (br_type_t)
//  res_taken      in   1   actual direction
//  res_tgt        in   32  actual target when taken
//  flush          in   1   exception/ertn flush; empties queue
//  branch_mistaken out 1   one-cycle redirect/BTB-fix pulse
//  wrong_pc       out  32  PC of mispredicted instruction
//  right_target   out  32  correct next PC
//  ins_type_w     out  3   res_type of mispredicted instruction
//  update_orien_en out 1   direction-train pulse (BR_COND only)
//  retire_pc      out  32  PC to train
//  right_orien    out  1   actual direction
//  q_err          out  1   sticky: resolve on empty queue or PC mismatch
// BEHAVIOUR
//  Reset (resetn=0 at posedge): head=tail=count=0, all outputs 0, q_err=0.
//  Entry = {pc, taken, tgt}. Push: slot 0 then slot 1, accepted only if push_ready, else both dropped (IF must stall).
//  Pop: res_valid pops head. Head compare is combinational; outputs are registered, visible cycle T+1 for resolve at T.
//  Mispredict at T when head.taken != res_taken, or (res_taken && head.tgt != res_tgt).
//  On mispredict:
//   - branch_mistaken=1, wrong_pc=res_pc, ins_type_w=res_type
//   - right_target = res_taken ? res_tgt : res_pc+4
//   - queue cleared at T; pushes at T and T+1 dropped (wrong path)
//  update_orien_en=1 at T+1 iff res_valid && res_type==BR_COND, with retire_pc=res_pc, right_orien=res_taken, independent of mispredict.
//  Non-branch predicted taken (BTB alias) -> mispredict with ins_type_w=BR_NOP, right_target=pc+4.
//  Push and pop in the same cycle: count += pushes-1; pointers wrap mod QDEPTH.
//  flush: clears queue, drops same-cycle pushes and resolve, suppresses T+1 outputs; flush beats mispredict.
//  Resolve when count==0, or res_pc != head.pc: q_err<=1, no pop, no outputs. Only reset clears q_err.
//  All output pulses last exactly one cycle; data outputs hold their last value otherwise.
//  Throughput: 1 resolve/cycle, 2 pushes/cycle.
// STRUCTURE
//  definitions.svh: br_type_t / BR_NOP, BR_COND, BR_JMP, BR_CALL, BR_RET, BR_IND (3-bit); pred_entry_t struct.
//  Sub-module pred_queue: dual-push/single-pop circular FIFO with clear. Outputs head entry, count, push_ready.
//  Compare logic and output registers live in pred_resolve.
// TESTING
//  1. Push pc 0x1c000000 taken=0; resolve BR_NOP not-taken -> no pulses, count 1->0.
//  2. Push 0x1c000010 taken=1 tgt 0x1c000100; resolve BR_COND taken tgt 0x1c000100 -> update_orien_en, right_orien=1, retire_pc=0x1c000010, no branch_mistaken.
//  3. Same push with actual not-taken -> branch_mistaken, right_target=0x1c000014, update_orien_en=1/right_orien=0. Queue of 3 older-pushed entries cleared; next-cycle push ignored.
//  4. Push 0x1c000020 taken=1 tgt 0x1c000200; resolve BR_IND taken tgt 0x1c000300 -> branch_mistaken, ins_type_w=BR_IND, right_target=0x1c000300, no update_orien_en.
//  5. Fill to QDEPTH-1: push_ready=0 and dual push dropped. Then push+pop across wrap (10 cycles) -> FIFO order preserved, count exact.
//  6. flush with a same-cycle mispredicting resolve -> no output pulses, count=0. Resolve on empty -> q_err=1 until resetn=0.

Source files
------------

// File: rtl/pred_resolve_pkg.sv
// Shared types for the branch prediction resolve path: branch type encoding
// and the per-instruction prediction record held in the in-order queue.
package pred_resolve_pkg;

    typedef enum logic [2:0] {
        BR_NOP  = 3'd0,
        BR_COND = 3'd1,
        BR_JMP  = 3'd2,
        BR_CALL = 3'd3,
        BR_RET  = 3'd4,
        BR_IND  = 3'd5
    } br_type_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } pred_entry_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/pred_queue.sv
// Dual-push / single-pop circular FIFO of predictions with a synchronous clear.
// Slot 1 is always written behind slot 0, so a same-cycle pair keeps fetch order.
module pred_queue
    import pred_resolve_pkg::*;
#(
    parameter int QDEPTH = 8,
    parameter int QIDLEN = $clog2(QDEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              push_0,
    input  logic              push_1,
    input  pred_entry_t       entry_0,
    input  pred_entry_t       entry_1,
    input  logic              pop,
    output pred_entry_t       head_entry,
    output logic [QIDLEN:0]   count,
    output logic              push_ready
);

    localparam int CW = QIDLEN + 1;

    pred_entry_t       mem [QDEPTH];
    logic [QIDLEN-1:0] head;
    logic [QIDLEN-1:0] tail;
    logic [QIDLEN-1:0] tail_p1;
    logic [QIDLEN:0]   n_push;
    logic [QIDLEN:0]   n_pop;

    assign tail_p1    = tail + 1'b1;
    assign n_push     = CW'(push_0) + CW'(push_1);
    assign n_pop      = CW'(pop);
    assign head_entry = mem[head];
    assign push_ready = (count <= CW'(QDEPTH - 2));

    // Storage write: slot 0 lands at tail, slot 1 right behind it
    always_ff @(posedge clk) begin
        if (push_0) mem[tail] <= entry_0;
        if (push_1) mem[tail_p1] <= entry_1;
    end

    // Pointer and occupancy update; clear wins over any same-cycle push/pop
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + n_push[QIDLEN-1:0];
            head  <= head + n_pop[QIDLEN-1:0];
            count <= count + n_push - n_pop;
        end
    end

endmodule

// File: rtl/pred_resolve.sv
// Compares each executed instruction with its queued prediction and drives
// the predictor update / front-end redirect interface one cycle later.
module pred_resolve
    import pred_resolve_pkg::*;
#(
    parameter int QDEPTH = 8,
    parameter int QIDLEN = $clog2(QDEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push_valid_0,
    input  logic        push_valid_1,
    input  logic [31:0] push_pc_0,
    input  logic [31:0] push_pc_1,
    input  logic        push_taken_0,
    input  logic        push_taken_1,
    input  logic [31:0] push_tgt_0,
    input  logic [31:0] push_tgt_1,
    output logic        push_ready,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic [2:0]  res_type,
    input  logic        res_taken,
    input  logic [31:0] res_tgt,
    input  logic        flush,
    output logic        branch_mistaken,
    output logic [31:0] wrong_pc,
    output logic [31:0] right_target,
    output logic [2:0]  ins_type_w,
    output logic        update_orien_en,
    output logic [31:0] retire_pc,
    output logic        right_orien,
    output logic        q_err
);

    pred_entry_t     head_entry;
    pred_entry_t     entry_0;
    pred_entry_t     entry_1;
    logic [QIDLEN:0] q_count;
    logic            head_match;
    logic            res_ok;
    logic            res_bad;
    logic            mispredict;
    logic            drop_next;
    logic            push_block;
    logic            push_0;
    logic            push_1;
    logic            q_clear;

    assign entry_0 = '{pc: push_pc_0, taken: push_taken_0, tgt: push_tgt_0};
    assign entry_1 = '{pc: push_pc_1, taken: push_taken_1, tgt: push_tgt_1};

    // A resolve is only trusted when it names the instruction at the head
    assign head_match = (q_count != '0) && (res_pc == head_entry.pc);
    assign res_ok     = res_valid && !flush && head_match;
    assign res_bad    = res_valid && !flush && !head_match;
    assign mispredict = res_ok && ((head_entry.taken != res_taken) ||
                                   (res_taken && (head_entry.tgt != res_tgt)));

    // Fetch packets during a redirect cycle and the cycle after are wrong-path
    assign push_block = flush || mispredict || drop_next;
    assign push_0     = push_valid_0 && push_ready && !push_block;
    assign push_1     = push_0 && push_valid_1;
    assign q_clear    = flush || mispredict;

    pred_queue #(
        .QDEPTH (QDEPTH),
        .QIDLEN (QIDLEN)
    ) u_queue (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (q_clear),
        .push_0     (push_0),
        .push_1     (push_1),
        .entry_0    (entry_0),
        .entry_1    (entry_1),
        .pop        (res_ok),
        .head_entry (head_entry),
        .count      (q_count),
        .push_ready (push_ready)
    );

    // Registered redirect/training outputs; pulses for one cycle, data holds
    always_ff @(posedge clk) begin
        if (!resetn) begin
            branch_mistaken <= 1'b0;
            wrong_pc        <= '0;
            right_target    <= '0;
            ins_type_w      <= '0;
            update_orien_en <= 1'b0;
            retire_pc       <= '0;
            right_orien     <= 1'b0;
            q_err           <= 1'b0;
            drop_next       <= 1'b0;
        end else begin
            branch_mistaken <= mispredict;
            drop_next       <= mispredict;
            update_orien_en <= res_ok && (res_type == BR_COND);
            if (mispredict) begin
                wrong_pc     <= res_pc;
                ins_type_w   <= res_type;
                right_target <= res_taken ? res_tgt : res_pc + 32'(PC_STEP);
            end
            if (res_ok && (res_type == BR_COND)) begin
                retire_pc   <= res_pc;
                right_orien <= res_taken;
            end
            if (res_bad) q_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pred_resolve.sv
// Directed bench for pred_resolve: each task drives one scenario and checks
// the registered outputs one cycle after the resolving edge.
module tb_pred_resolve;
    import pred_resolve_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        push_valid_0, push_valid_1;
    logic [31:0] push_pc_0, push_pc_1;
    logic        push_taken_0, push_taken_1;
    logic [31:0] push_tgt_0, push_tgt_1;
    logic        push_ready;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [2:0]  res_type;
    logic        res_taken;
    logic [31:0] res_tgt;
    logic        flush;
    logic        branch_mistaken;
    logic [31:0] wrong_pc;
    logic [31:0] right_target;
    logic [2:0]  ins_type_w;
    logic        update_orien_en;
    logic [31:0] retire_pc;
    logic        right_orien;
    logic        q_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pred_resolve dut (
        .clk             (clk),
        .resetn          (resetn),
        .push_valid_0    (push_valid_0),
        .push_valid_1    (push_valid_1),
        .push_pc_0       (push_pc_0),
        .push_pc_1       (push_pc_1),
        .push_taken_0    (push_taken_0),
        .push_taken_1    (push_taken_1),
        .push_tgt_0      (push_tgt_0),
        .push_tgt_1      (push_tgt_1),
        .push_ready      (push_ready),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_type        (res_type),
        .res_taken       (res_taken),
        .res_tgt         (res_tgt),
        .flush           (flush),
        .branch_mistaken (branch_mistaken),
        .wrong_pc        (wrong_pc),
        .right_target    (right_target),
        .ins_type_w      (ins_type_w),
        .update_orien_en (update_orien_en),
        .retire_pc       (retire_pc),
        .right_orien     (right_orien),
        .q_err           (q_err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        push_valid_0 = 1'b0; push_valid_1 = 1'b0;
        push_pc_0 = '0; push_pc_1 = '0;
        push_taken_0 = 1'b0; push_taken_1 = 1'b0;
        push_tgt_0 = '0; push_tgt_1 = '0;
        res_valid = 1'b0; res_pc = '0; res_type = '0;
        res_taken = 1'b0; res_tgt = '0;
        flush = 1'b0;
    endtask

    task automatic set_push0(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        push_valid_0 = 1'b1; push_pc_0 = pc; push_taken_0 = tk; push_tgt_0 = tgt;
    endtask

    task automatic set_push1(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        push_valid_1 = 1'b1; push_pc_1 = pc; push_taken_1 = tk; push_tgt_1 = tgt;
    endtask

    task automatic set_res(input logic [31:0] pc, input br_type_t ty, input logic tk,
                           input logic [31:0] tgt);
        res_valid = 1'b1; res_pc = pc; res_type = ty; res_taken = tk; res_tgt = tgt;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        idle_inputs();
        step(); step();
        checks++; if (branch_mistaken !== 1'b0 || update_orien_en !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_pulses: got %0b/%0b want 0/0", branch_mistaken, update_orien_en); end
        checks++; if (wrong_pc !== 32'h0 || right_target !== 32'h0 || retire_pc !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_data: got %h/%h/%h want 0", wrong_pc, right_target, retire_pc); end
        checks++; if (q_err !== 1'b0 || dut.q_count !== 4'd0 || push_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_queue: q_err=%0b count=%0d ready=%0b want 0/0/1", q_err, dut.q_count, push_ready); end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_nop;
        set_push0(32'h1c000000, 1'b0, 32'h0);
        step(); idle_inputs();
        checks++; if (dut.q_count !== 4'd1) begin
            errors++; $display("[TB] FAIL nop_count_push: got %0d want 1", dut.q_count); end
        set_res(32'h1c000000, BR_NOP, 1'b0, 32'h0);
        step(); idle_inputs();
        checks++; if (branch_mistaken !== 1'b0 || update_orien_en !== 1'b0) begin
            errors++; $display("[TB] FAIL nop_pulses: got %0b/%0b want 0/0", branch_mistaken, update_orien_en); end
        checks++; if (dut.q_count !== 4'd0) begin
            errors++; $display("[TB] FAIL nop_count_pop: got %0d want 0", dut.q_count); end
    endtask

    task automatic test_cond_correct;
        set_push0(32'h1c000010, 1'b1, 32'h1c000100);
        step(); idle_inputs();
        set_res(32'h1c000010, BR_COND, 1'b1, 32'h1c000100);
        step(); idle_inputs();
        checks++; if (update_orien_en !== 1'b1 || right_orien !== 1'b1 || retire_pc !== 32'h1c000010) begin
            errors++; $display("[TB] FAIL cond_train: got en=%0b orien=%0b pc=%h want 1/1/1c000010",
                               update_orien_en, right_orien, retire_pc); end
        checks++; if (branch_mistaken !== 1'b0) begin
            errors++; $display("[TB] FAIL cond_no_redirect: got %0b want 0", branch_mistaken); end
        step();
        checks++; if (update_orien_en !== 1'b0 || retire_pc !== 32'h1c000010) begin
            errors++; $display("[TB] FAIL cond_pulse_len: got en=%0b pc=%h want 0/1c000010", update_orien_en, retire_pc); end
    endtask

    task automatic test_cond_mispredict;
        set_push0(32'h1c000010, 1'b1, 32'h1c000100);
        step(); idle_inputs();
        set_push0(32'h1c000100, 1'b0, 32'h0);
        set_push1(32'h1c000104, 1'b0, 32'h0);
        step(); idle_inputs();
        checks++; if (dut.q_count !== 4'd3) begin
            errors++; $display("[TB] FAIL mis_fill: got %0d want 3", dut.q_count); end
        set_res(32'h1c000010, BR_COND, 1'b0, 32'h0);
        set_push0(32'h1c000108, 1'b0, 32'h0);
        step(); idle_inputs();
        checks++; if (branch_mistaken !== 1'b1 || wrong_pc !== 32'h1c000010 || right_target !== 32'h1c000014) begin
            errors++; $display("[TB] FAIL mis_redirect: got %0b pc=%h tgt=%h want 1/1c000010/1c000014",
                               branch_mistaken, wrong_pc, right_target); end
        checks++; if (ins_type_w !== 3'd1 || update_orien_en !== 1'b1 || right_orien !== 1'b0) begin
            errors++; $display("[TB] FAIL mis_train: got type=%0d en=%0b orien=%0b want 1/1/0",
                               ins_type_w, update_orien_en, right_orien); end
        checks++; if (dut.q_count !== 4'd0) begin
            errors++; $display("[TB] FAIL mis_clear: got %0d want 0", dut.q_count); end
        set_push0(32'h1c000014, 1'b0, 32'h0);
        step(); idle_inputs();
        checks++; if (dut.q_count !== 4'd0 || branch_mistaken !== 1'b0) begin
            errors++; $display("[TB] FAIL mis_drop_next: got count=%0d bm=%0b want 0/0", dut.q_count, branch_mistaken); end
        set_push0(32'h1c000014, 1'b0, 32'h0);
        step(); idle_inputs();
        checks++; if (dut.q_count !== 4'd1) begin
            errors++; $display("[TB] FAIL mis_resume: got %0d want 1", dut.q_count); end
        set_res(32'h1c000014, BR_NOP, 1'b0, 32'h0);
        step(); idle_inputs();
    endtask

    task automatic test_indirect;
        set_push0(32'h1c000020, 1'b1, 32'h1c000200);
        step(); idle_inputs();
        set_res(32'h1c000020, BR_IND, 1'b1, 32'h1c000300);
        step(); idle_inputs();
        checks++; if (branch_mistaken !== 1'b1 || ins_type_w !== 3'd5 || right_target !== 32'h1c000300) begin
            errors++; $display("[TB] FAIL ind_redirect: got %0b type=%0d tgt=%h want 1/5/1c000300",
                               branch_mistaken, ins_type_w, right_target); end
        checks++; if (update_orien_en !== 1'b0 || wrong_pc !== 32'h1c000020) begin
            errors++; $display("[TB] FAIL ind_train: got en=%0b pc=%h want 0/1c000020", update_orien_en, wrong_pc); end
        step();
        // BTB alias: plain instruction predicted taken
        set_push0(32'h1c000030, 1'b1, 32'h1c000400);
        step(); idle_inputs();
        set_res(32'h1c000030, BR_NOP, 1'b0, 32'h0);
        step(); idle_inputs();
        checks++; if (branch_mistaken !== 1'b1 || ins_type_w !== 3'd0 || right_target !== 32'h1c000034) begin
            errors++; $display("[TB] FAIL alias_redirect: got %0b type=%0d tgt=%h want 1/0/1c000034",
                               branch_mistaken, ins_type_w, right_target); end
        step();
        checks++; if (branch_mistaken !== 1'b0 || wrong_pc !== 32'h1c000030) begin
            errors++; $display("[TB] FAIL alias_hold: got %0b pc=%h want 0/1c000030", branch_mistaken, wrong_pc); end
    endtask

    task automatic test_full_wrap;
        logic [31:0] exp_q[$];
        logic [31:0] next_pc;
        logic [31:0] pc;
        next_pc = 32'h1c001000;
        for (int i = 0; i < 3; i++) begin
            set_push0(next_pc, 1'b0, 32'h0);
            set_push1(next_pc + 32'd4, 1'b0, 32'h0);
            exp_q.push_back(next_pc);
            exp_q.push_back(next_pc + 32'd4);
            next_pc += 32'd8;
            step(); idle_inputs();
        end
        checks++; if (dut.q_count !== 4'd6 || push_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL full_six: got count=%0d ready=%0b want 6/1", dut.q_count, push_ready); end
        set_push0(next_pc, 1'b0, 32'h0);
        exp_q.push_back(next_pc);
        next_pc += 32'd4;
        step(); idle_inputs();
        checks++; if (dut.q_count !== 4'd7 || push_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL full_seven: got count=%0d ready=%0b want 7/0", dut.q_count, push_ready); end
        set_push0(32'h1c00f000, 1'b0, 32'h0);
        set_push1(32'h1c00f004, 1'b0, 32'h0);
        step(); idle_inputs();
        checks++; if (dut.q_count !== 4'd7) begin
            errors++; $display("[TB] FAIL full_drop: got %0d want 7", dut.q_count); end
        pc = exp_q.pop_front();
        set_res(pc, BR_COND, 1'b0, 32'h0);
        step(); idle_inputs();
        checks++; if (retire_pc !== pc || dut.q_count !== 4'd6) begin
            errors++; $display("[TB] FAIL full_pop: got pc=%h count=%0d want %h/6", retire_pc, dut.q_count, pc); end
        for (int i = 0; i < 10; i++) begin
            pc = exp_q.pop_front();
            set_res(pc, BR_COND, 1'b0, 32'h0);
            set_push0(next_pc, 1'b0, 32'h0);
            exp_q.push_back(next_pc);
            next_pc += 32'd4;
            step(); idle_inputs();
            checks++; if (retire_pc !== pc || update_orien_en !== 1'b1 || right_orien !== 1'b0) begin
                errors++; $display("[TB] FAIL wrap_order[%0d]: got pc=%h en=%0b want %h/1", i, retire_pc, update_orien_en, pc); end
            checks++; if (dut.q_count !== 4'd6 || branch_mistaken !== 1'b0) begin
                errors++; $display("[TB] FAIL wrap_count[%0d]: got count=%0d bm=%0b want 6/0", i, dut.q_count, branch_mistaken); end
        end
        while (exp_q.size() > 0) begin
            pc = exp_q.pop_front();
            set_res(pc, BR_COND, 1'b0, 32'h0);
            step(); idle_inputs();
            checks++; if (retire_pc !== pc) begin
                errors++; $display("[TB] FAIL drain_order: got %h want %h", retire_pc, pc); end
        end
        checks++; if (dut.q_count !== 4'd0 || q_err !== 1'b0) begin
            errors++; $display("[TB] FAIL drain_end: got count=%0d q_err=%0b want 0/0", dut.q_count, q_err); end
    endtask

    task automatic test_flush;
        set_push0(32'h1c002000, 1'b1, 32'h1c002100);
        set_push1(32'h1c002100, 1'b0, 32'h0);
        step(); idle_inputs();
        set_res(32'h1c002000, BR_COND, 1'b0, 32'h0);
        set_push0(32'h1c003000, 1'b0, 32'h0);
        flush = 1'b1;
        step(); idle_inputs();
        checks++; if (branch_mistaken !== 1'b0 || update_orien_en !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_pulses: got %0b/%0b want 0/0", branch_mistaken, update_orien_en); end
        checks++; if (dut.q_count !== 4'd0 || q_err !== 1'b0 || wrong_pc !== 32'h1c000030) begin
            errors++; $display("[TB] FAIL flush_state: got count=%0d q_err=%0b pc=%h want 0/0/1c000030",
                               dut.q_count, q_err, wrong_pc); end
    endtask

    task automatic test_qerr;
        set_res(32'h1c004000, BR_JMP, 1'b1, 32'h1c004100);
        step(); idle_inputs();
        checks++; if (q_err !== 1'b1 || branch_mistaken !== 1'b0) begin
            errors++; $display("[TB] FAIL qerr_empty: got q_err=%0b bm=%0b want 1/0", q_err, branch_mistaken); end
        step(); step();
        checks++; if (q_err !== 1'b1) begin
            errors++; $display("[TB] FAIL qerr_sticky: got %0b want 1", q_err); end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checks++; if (q_err !== 1'b0) begin
            errors++; $display("[TB] FAIL qerr_reset: got %0b want 0", q_err); end
        set_push0(32'h1c005000, 1'b0, 32'h0);
        step(); idle_inputs();
        set_res(32'h1c005004, BR_COND, 1'b0, 32'h0);
        step(); idle_inputs();
        checks++; if (q_err !== 1'b1 || dut.q_count !== 4'd1 || update_orien_en !== 1'b0) begin
            errors++; $display("[TB] FAIL qerr_pc: got q_err=%0b count=%0d en=%0b want 1/1/0",
                               q_err, dut.q_count, update_orien_en); end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_cond_correct();
        test_cond_mispredict();
        test_indirect();
        test_full_wrap();
        test_flush();
        test_qerr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
